// File: rtl/seg_display_scheduler.sv
// Scan controller and arbiter for a 4-digit seven-segment display.
// The live level with peak hold owns the display by default. A timed override
// request can take it over for OVR_TIME cycles and can be retriggered.
module seg_display_scheduler #(
    parameter int SCAN_DIV  = 100000,
    parameter int PEAK_HOLD = 50000000,
    parameter int OVR_TIME  = 100000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  level,
    input  logic        level_valid,
    input  logic        ovr_req,
    input  logic [15:0] ovr_digits,
    output logic        ovr_ack,
    output logic [3:0]  an,
    output logic [6:0]  seg
);

    localparam int SW = (SCAN_DIV  > 2) ? $clog2(SCAN_DIV)  : 1;
    localparam int HW = (PEAK_HOLD > 2) ? $clog2(PEAK_HOLD) : 1;
    localparam int OW = (OVR_TIME  > 2) ? $clog2(OVR_TIME)  : 1;

    typedef enum logic {IDLE, OVERRIDE} state_t;

    state_t        state, state_next;
    logic [SW-1:0] prescaler;
    logic [1:0]    idx;
    logic [3:0]    live, live_next;
    logic [3:0]    peak;
    logic [HW-1:0] hold_timer;
    logic [OW-1:0] ovr_timer;
    logic [15:0]   ovr_latch;
    logic          ovr_load;
    logic          ovr_tick;
    logic [3:0]    nibble;

    // Active-low segment pattern {g,f,e,d,c,b,a} for one hex nibble.
    function automatic logic [6:0] seg_code(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0011000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Levels are at most 15, so the tens digit is 0 or 1.
    function automatic logic [3:0] dec_tens(input logic [3:0] v);
        return (v >= 4'd10) ? 4'd1 : 4'd0;
    endfunction

    function automatic logic [3:0] dec_units(input logic [3:0] v);
        return (v >= 4'd10) ? (v - 4'd10) : v;
    endfunction

    // Digit scan: the prescaler sets the dwell time per digit, idx walks 0..3.
    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler <= '0;
            idx       <= 2'd0;
        end else if (prescaler == SW'(SCAN_DIV - 1)) begin
            prescaler <= '0;
            idx       <= idx + 2'd1;
        end else begin
            prescaler <= prescaler + SW'(1);
        end
    end

    // The value live takes this cycle; decay compares against it so the peak
    // can never drop below a level that is being loaded at the same moment.
    always_comb begin
        live_next = level_valid ? level : live;
    end

    // Live level capture and peak hold with a slow 1-step decay.
    always_ff @(posedge clk) begin
        if (reset) begin
            live       <= 4'd0;
            peak       <= 4'd0;
            hold_timer <= '0;
        end else begin
            live <= live_next;
            if (level_valid && (level > peak)) begin
                peak       <= level;
                hold_timer <= '0;
            end else if (hold_timer == HW'(PEAK_HOLD - 1)) begin
                hold_timer <= '0;
                if (peak > live_next)
                    peak <= peak - 4'd1;
            end else begin
                hold_timer <= hold_timer + HW'(1);
            end
        end
    end

    // Ownership FSM state register.
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Ownership FSM: a request (re)starts the override, expiry returns to IDLE.
    always_comb begin
        state_next = state;
        ovr_load   = 1'b0;
        ovr_tick   = 1'b0;
        case (state)
            IDLE: begin
                if (ovr_req) begin
                    ovr_load   = 1'b1;
                    state_next = OVERRIDE;
                end
            end
            OVERRIDE: begin
                if (ovr_req)
                    ovr_load = 1'b1;
                else if (ovr_timer == OW'(OVR_TIME - 1))
                    state_next = IDLE;
                else
                    ovr_tick = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    // Override content latch, ownership timer and acknowledge pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovr_timer <= '0;
            ovr_latch <= 16'h0000;
            ovr_ack   <= 1'b0;
        end else begin
            ovr_ack <= ovr_load;
            if (ovr_load) begin
                ovr_latch <= ovr_digits;
                ovr_timer <= '0;
            end else if (ovr_tick) begin
                ovr_timer <= ovr_timer + OW'(1);
            end
        end
    end

    // Nibble for the digit currently being scanned, from whichever owner holds the display.
    always_comb begin
        nibble = 4'h0;
        if (state == OVERRIDE) begin
            case (idx)
                2'd0:    nibble = ovr_latch[3:0];
                2'd1:    nibble = ovr_latch[7:4];
                2'd2:    nibble = ovr_latch[11:8];
                default: nibble = ovr_latch[15:12];
            endcase
        end else begin
            case (idx)
                2'd0:    nibble = dec_units(live);
                2'd1:    nibble = dec_tens(live);
                2'd2:    nibble = dec_units(peak);
                default: nibble = dec_tens(peak);
            endcase
        end
    end

    // Registered pin drivers; blanked while in reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            an  <= 4'b1111;
            seg <= 7'b1111111;
        end else begin
            an  <= ~(4'b0001 << idx);
            seg <= seg_code(nibble);
        end
    end

endmodule

// File: tb/tb_seg_display_scheduler.sv
module tb_seg_display_scheduler;

    localparam int SCAN_DIV  = 4;
    localparam int PEAK_HOLD = 8;
    localparam int OVR_TIME  = 20;

    localparam logic [6:0] SEG_TAB [0:15] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  level = 4'd0;
    logic        level_valid = 1'b0;
    logic        ovr_req = 1'b0;
    logic [15:0] ovr_digits = 16'h0000;
    logic        ovr_ack;
    logic [3:0]  an;
    logic [6:0]  seg;

    int vectors = 0;
    int miscompares = 0;

    logic [11:0] exp_q [$];

    int m_live = 0, m_peak = 0, m_hold = 0, m_scan = 0, m_ovr_left = 0;
    int m_ovr_val = 0;

    seg_display_scheduler #(
        .SCAN_DIV(SCAN_DIV), .PEAK_HOLD(PEAK_HOLD), .OVR_TIME(OVR_TIME)
    ) dut (
        .clk(clk), .reset(reset), .level(level), .level_valid(level_valid),
        .ovr_req(ovr_req), .ovr_digits(ovr_digits), .ovr_ack(ovr_ack),
        .an(an), .seg(seg)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        logic [11:0] e;
        int digit, val, nib, live_n;
        if (reset) begin
            m_live = 0; m_peak = 0; m_hold = 0; m_scan = 0; m_ovr_left = 0;
            e = {1'b0, 4'b1111, 7'b1111111};
        end else begin
            digit = m_scan / SCAN_DIV;
            if (m_ovr_left > 0) begin
                nib = (m_ovr_val >> (4 * digit)) & 15;
            end else begin
                val = (digit < 2) ? m_live : m_peak;
                nib = (digit % 2 == 0) ? (val % 10) : (val / 10);
            end
            e = {ovr_req, ~(4'b0001 << digit), SEG_TAB[nib]};
            m_scan = (m_scan + 1) % (4 * SCAN_DIV);
            live_n = level_valid ? int'(level) : m_live;
            if (level_valid && int'(level) > m_peak) begin
                m_peak = int'(level);
                m_hold = 0;
            end else begin
                m_hold++;
                if (m_hold == PEAK_HOLD) begin
                    m_hold = 0;
                    if (m_peak > live_n) m_peak--;
                end
            end
            m_live = live_n;
            if (ovr_req) begin
                m_ovr_val  = int'(ovr_digits);
                m_ovr_left = OVR_TIME;
            end else if (m_ovr_left > 0) begin
                m_ovr_left--;
            end
        end
        exp_q.push_back(e);
    end

    always @(negedge clk) begin
        logic [11:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if ({ovr_ack, an, seg} !== e) begin
                miscompares++;
                $display("FAIL pins t=%0t got ack=%b an=%b seg=%b want ack=%b an=%b seg=%b",
                         $time, ovr_ack, an, seg, e[11], e[10:7], e[6:0]);
            end
        end
    end

    task automatic check(input logic ok, input string msg);
        vectors++;
        if (ok !== 1'b1) begin
            miscompares++;
            $display("FAIL %s t=%0t ack=%b an=%b seg=%b", msg, $time, ovr_ack, an, seg);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_level(input logic [3:0] v);
        @(negedge clk);
        level = v; level_valid = 1'b1;
        @(negedge clk);
        level_valid = 1'b0;
    endtask

    task automatic pulse_ovr(input logic [15:0] d, input int len);
        @(negedge clk);
        ovr_digits = d; ovr_req = 1'b1;
        repeat (len) @(negedge clk);
        ovr_req = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle(3);
        check((ovr_ack === 1'b0) && (an === 4'b1111) && (seg === 7'b1111111), "reset state");
        reset = 1'b0;
        idle(20);
        pulse_level(4'd13);
        idle(20);
        pulse_level(4'd2);
        idle(30);
        pulse_level(4'd9);
        idle(130);
        pulse_level(4'd14);
        idle(7);
        pulse_level(4'd15);
        idle(20);
        pulse_ovr(16'hA5C0, 1);
        check(ovr_ack === 1'b1, "ovr ack pulse");
        idle(30);
        check((ovr_ack === 1'b0) && (m_ovr_left == 0), "override expired");
        pulse_ovr(16'h1234, 1);
        idle(14);
        pulse_ovr(16'hBEEF, 1);
        idle(40);
        pulse_ovr(16'hFD09, 5);
        idle(25);
        pulse_level(4'd11);
        pulse_ovr(16'h7777, 1);
        idle(5);
        reset = 1'b1;
        idle(2);
        check((ovr_ack === 1'b0) && (an === 4'b1111) && (seg === 7'b1111111), "reset mid-override");
        reset = 1'b0;
        idle(20);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            level       = 4'($urandom_range(0, 15));
            level_valid = ($urandom_range(0, 3) == 0);
            ovr_req     = ($urandom_range(0, 39) == 0);
            ovr_digits  = 16'($urandom);
            reset       = ($urandom_range(0, 599) == 0);
        end
        @(negedge clk);
        reset = 1'b0; level_valid = 1'b0; ovr_req = 1'b0;
        idle(5);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
